// File: rtl/bisection_sequencer.sv
// rtl/bisection_sequencer.sv - bisection root-finding iteration controller for a shared evaluator
module bisection_sequencer #(
  parameter int W    = 20,
  parameter int FRAC = 15,
  parameter int IW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a_init,
  input  logic [W-1:0]  b_init,
  input  logic [W-1:0]  tol_f,
  input  logic [W-1:0]  tol_x,
  input  logic [IW-1:0] max_iter,
  output logic          eval_req,
  output logic [W-1:0]  eval_x,
  input  logic          eval_ack,
  input  logic [W-1:0]  eval_fx,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  root,
  output logic [W-1:0]  f_root,
  output logic [IW-1:0] iters,
  output logic [1:0]    status
);

  // FRAC only documents the number format; no rescaling happens here.
  if (FRAC >= W) begin : g_frac_check
    $error("FRAC must be smaller than W");
  end

  localparam logic [1:0] ST_FTOL   = 2'b00;
  localparam logic [1:0] ST_XTOL   = 2'b01;
  localparam logic [1:0] ST_LIMIT  = 2'b10;
  localparam logic [1:0] ST_NOSIGN = 2'b11;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL_A,
    S_EVAL_B,
    S_CHECK,
    S_EVAL_M,
    S_UPDATE,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  fa_q, fa_d;
  logic [W-1:0]  fb_q, fb_d;
  logic [W-1:0]  fm_q, fm_d;
  logic [W-1:0]  tol_f_q, tol_f_d;
  logic [W-1:0]  tol_x_q, tol_x_d;
  logic [IW-1:0] max_iter_q, max_iter_d;
  logic          eval_req_q, eval_req_d;
  logic [W-1:0]  eval_x_q, eval_x_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  root_q, root_d;
  logic [W-1:0]  f_root_q, f_root_d;
  logic [IW-1:0] iters_q, iters_d;
  logic [1:0]    status_q, status_d;

  // Midpoint in W+1 bits: the sum cannot overflow and dropping bit 0 is an
  // arithmetic shift, i.e. truncation toward -inf.
  logic [W:0]    sum_w;
  logic [W-1:0]  mid;
  assign sum_w = {a_q[W-1], a_q} + {b_q[W-1], b_q};
  assign mid   = sum_w[W:1];

  // |fm| with the most negative value saturated so it stays representable.
  logic [W-1:0]  fm_mag;
  assign fm_mag = !fm_q[W-1] ? fm_q : ((fm_q == MOST_NEG) ? MAX_POS : -fm_q);

  // Candidate interval after the sign-change test on the midpoint.
  logic          keep_left;
  logic [W-1:0]  upd_a, upd_b;
  logic [W:0]    width_w;
  logic [IW-1:0] iters_inc;
  assign keep_left = (fa_q[W-1] != fm_q[W-1]);
  assign upd_a     = keep_left ? a_q : mid;
  assign upd_b     = keep_left ? mid : b_q;
  assign width_w   = {upd_b[W-1], upd_b} - {upd_a[W-1], upd_a};
  assign iters_inc = iters_q + IW'(1);

  // Next-state, handshake and result computation.
  always_comb begin
    logic finish_now;
    finish_now  = 1'b0;
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    fm_d        = fm_q;
    tol_f_d     = tol_f_q;
    tol_x_d     = tol_x_q;
    max_iter_d  = max_iter_q;
    eval_req_d  = eval_req_q;
    eval_x_d    = eval_x_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    root_d      = root_q;
    f_root_d    = f_root_q;
    iters_d     = iters_q;
    status_d    = status_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = a_init;
          b_d        = b_init;
          tol_f_d    = tol_f;
          tol_x_d    = tol_x;
          max_iter_d = max_iter;
          iters_d    = '0;
          busy_d     = 1'b1;
          state_d    = S_EVAL_A;
        end
      end

      S_EVAL_A: begin
        if (!eval_req_q) begin
          eval_req_d = 1'b1;
          eval_x_d   = a_q;
        end else if (eval_ack) begin
          eval_req_d = 1'b0;
          fa_d       = eval_fx;
          state_d    = S_EVAL_B;
        end
      end

      S_EVAL_B: begin
        if (!eval_req_q) begin
          eval_req_d = 1'b1;
          eval_x_d   = b_q;
        end else if (eval_ack) begin
          eval_req_d = 1'b0;
          fb_d       = eval_fx;
          state_d    = S_CHECK;
        end
      end

      S_CHECK: begin
        if (fa_q == '0) begin
          root_d     = a_q;
          f_root_d   = fa_q;
          status_d   = ST_FTOL;
          finish_now = 1'b1;
        end else if (fb_q == '0) begin
          root_d     = b_q;
          f_root_d   = fb_q;
          status_d   = ST_FTOL;
          finish_now = 1'b1;
        end else if (fa_q[W-1] == fb_q[W-1]) begin
          root_d     = a_q;
          f_root_d   = fa_q;
          status_d   = ST_NOSIGN;
          finish_now = 1'b1;
        end else if (max_iter_q == '0) begin
          root_d     = a_q;
          f_root_d   = fa_q;
          status_d   = ST_LIMIT;
          finish_now = 1'b1;
        end else begin
          state_d    = S_EVAL_M;
        end
      end

      S_EVAL_M: begin
        if (!eval_req_q) begin
          eval_req_d = 1'b1;
          eval_x_d   = mid;
        end else if (eval_ack) begin
          eval_req_d = 1'b0;
          fm_d       = eval_fx;
          state_d    = S_UPDATE;
        end
      end

      S_UPDATE: begin
        iters_d  = iters_inc;
        root_d   = mid;
        f_root_d = fm_q;
        if (fm_mag <= tol_f_q) begin
          status_d   = ST_FTOL;
          finish_now = 1'b1;
        end else begin
          a_d = upd_a;
          b_d = upd_b;
          if (!keep_left) begin
            fa_d = fm_q;
          end
          if (width_w <= {1'b0, tol_x_q}) begin
            status_d   = ST_XTOL;
            finish_now = 1'b1;
          end else if (iters_inc == max_iter_q) begin
            status_d   = ST_LIMIT;
            finish_now = 1'b1;
          end else begin
            state_d    = S_EVAL_M;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish_now) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_FINISH;
    end
  end

  // State and datapath registers; reset abandons any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      fa_q       <= '0;
      fb_q       <= '0;
      fm_q       <= '0;
      tol_f_q    <= '0;
      tol_x_q    <= '0;
      max_iter_q <= '0;
      eval_req_q <= 1'b0;
      eval_x_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      root_q     <= '0;
      f_root_q   <= '0;
      iters_q    <= '0;
      status_q   <= ST_FTOL;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      fm_q       <= fm_d;
      tol_f_q    <= tol_f_d;
      tol_x_q    <= tol_x_d;
      max_iter_q <= max_iter_d;
      eval_req_q <= eval_req_d;
      eval_x_q   <= eval_x_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      root_q     <= root_d;
      f_root_q   <= f_root_d;
      iters_q    <= iters_d;
      status_q   <= status_d;
    end
  end

  assign eval_req = eval_req_q;
  assign eval_x   = eval_x_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign root     = root_q;
  assign f_root   = f_root_q;
  assign iters    = iters_q;
  assign status   = status_q;

endmodule

// File: tb/tb_bisection_sequencer.sv
// tb/tb_bisection_sequencer.sv - randomized self-checking bench for bisection_sequencer
module tb_bisection_sequencer;

  localparam int W  = 20;
  localparam int IW = 8;
  localparam longint MAXPOS = 64'd524287;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a_init, b_init, tol_f, tol_x;
  logic [IW-1:0] max_iter;
  logic          eval_req;
  logic [W-1:0]  eval_x;
  logic          eval_ack;
  logic [W-1:0]  eval_fx;
  logic          busy, done;
  logic [W-1:0]  root, f_root;
  logic [IW-1:0] iters;
  logic [1:0]    status;

  int checks = 0;
  int errors = 0;

  // evaluator model controls
  longint k_val = 0;
  bit     zero_wait = 0;
  bit     spurious = 0;
  int     stall_after = -1;
  int     req_count = 0;
  bit     req_seen = 0;
  int     remain = 0;
  logic [W-1:0] cur_x;
  longint obs_x[$];

  // reference model results
  longint exp_root, exp_froot;
  int     exp_iters, exp_status;
  longint exp_x[$];

  bisection_sequencer #(.W(W), .FRAC(15), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_init(a_init), .b_init(b_init), .tol_f(tol_f), .tol_x(tol_x),
    .max_iter(max_iter), .eval_req(eval_req), .eval_x(eval_x),
    .eval_ack(eval_ack), .eval_fx(eval_fx), .busy(busy), .done(done),
    .root(root), .f_root(f_root), .iters(iters), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] f_of(input logic [W-1:0] x);
    longint v;
    v = longint'($signed(x)) - k_val;
    return v[W-1:0];
  endfunction

  // Evaluator: f(x)=x-K, acks after a random 1..5 cycle latency (or immediately).
  initial begin
    eval_ack = 1'b0;
    eval_fx  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_seen = 0;
        eval_ack = 1'b0;
      end else if (eval_req) begin
        if (!req_seen) begin
          req_seen = 1;
          cur_x = eval_x;
          obs_x.push_back(longint'($signed(eval_x)));
          req_count++;
          remain = zero_wait ? 0 : int'($urandom_range(0, 4));
        end else begin
          checks++;
          if (eval_x !== cur_x) begin
            errors++;
            $display("FAIL eval_x_stable got %h exp %h", eval_x, cur_x);
          end
        end
        if (stall_after >= 0 && req_count > stall_after) begin
          eval_ack = 1'b0;
        end else if (remain == 0) begin
          eval_ack = 1'b1;
          eval_fx  = f_of(cur_x);
        end else begin
          eval_ack = 1'b0;
          remain--;
        end
      end else begin
        req_seen = 0;
        if (spurious) begin
          eval_ack = 1'($urandom_range(0, 1));
          eval_fx  = W'($urandom);
        end else begin
          eval_ack = 1'b0;
        end
      end
    end
  end

  // Bisection computed directly on integers from the algorithm's rules.
  task automatic model_run(input longint a, input longint b, input longint k,
                           input longint tf, input longint tx, input int mi);
    longint fa, fb, fm, m, mag;
    int it;
    exp_x.delete();
    exp_x.push_back(a);
    exp_x.push_back(b);
    fa = a - k;
    fb = b - k;
    it = 0;
    if (fa == 0) begin
      exp_root = a; exp_froot = 0; exp_status = 0;
    end else if (fb == 0) begin
      exp_root = b; exp_froot = 0; exp_status = 0;
    end else if ((fa < 0) == (fb < 0)) begin
      exp_root = a; exp_froot = fa; exp_status = 3;
    end else if (mi == 0) begin
      exp_root = a; exp_froot = fa; exp_status = 2;
    end else begin
      forever begin
        m = (a + b) >>> 1;
        exp_x.push_back(m);
        it++;
        fm = m - k;
        mag = (fm < 0) ? -fm : fm;
        if (mag > MAXPOS) mag = MAXPOS;
        exp_root = m;
        exp_froot = fm;
        if (mag <= tf) begin exp_status = 0; break; end
        if ((fa < 0) != (fm < 0)) b = m;
        else begin a = m; fa = fm; end
        if (b - a <= tx) begin exp_status = 1; break; end
        if (it == mi) begin exp_status = 2; break; end
      end
    end
    exp_iters = it;
  endtask

  task automatic run_case(input longint a, input longint b, input longint k,
                          input longint tf, input longint tx, input int mi,
                          input bit zw, input bit bs);
    int cyc;
    bit got;
    bit list_ok;
    model_run(a, b, k, tf, tx, mi);
    @(negedge clk);
    k_val = k;
    zero_wait = zw;
    obs_x.delete();
    req_count = 0;
    a_init = a[W-1:0];
    b_init = b[W-1:0];
    tol_f = tf[W-1:0];
    tol_x = tx[W-1:0];
    max_iter = IW'(mi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_init = W'($urandom);
    b_init = W'($urandom);
    tol_f = W'($urandom);
    tol_x = W'($urandom);
    max_iter = IW'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b exp 1", busy);
    end
    cyc = 0;
    got = 0;
    while (cyc < 3000 && !got) begin
      start = (bs && cyc == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1;
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout got none exp done within 3000 cycles");
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done got %b exp 0", busy);
      end
      checks++;
      if (longint'($signed(root)) !== exp_root) begin
        errors++;
        $display("FAIL root got %0d exp %0d", $signed(root), exp_root);
      end
      checks++;
      if (longint'($signed(f_root)) !== exp_froot) begin
        errors++;
        $display("FAIL f_root got %0d exp %0d", $signed(f_root), exp_froot);
      end
      checks++;
      if (int'(iters) !== exp_iters) begin
        errors++;
        $display("FAIL iters got %0d exp %0d", iters, exp_iters);
      end
      checks++;
      if (int'(status) !== exp_status) begin
        errors++;
        $display("FAIL status got %0d exp %0d", status, exp_status);
      end
      list_ok = (obs_x.size() == exp_x.size());
      if (list_ok) begin
        foreach (exp_x[i]) if (obs_x[i] != exp_x[i]) list_ok = 0;
      end
      checks++;
      if (!list_ok) begin
        errors++;
        $display("FAIL request_sequence got %0d requests exp %0d", obs_x.size(), exp_x.size());
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_one_cycle got %b exp 0", done);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a_init = '0; b_init = '0; tol_f = '0; tol_x = '0; max_iter = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({eval_req, eval_x, busy, done, root, f_root, iters, status} !== '0) begin
      errors++;
      $display("FAIL reset_values got req=%b x=%h busy=%b done=%b root=%h froot=%h it=%0d st=%0d exp all zero",
               eval_req, eval_x, busy, done, root, f_root, iters, status);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact_mid;
    run_case(64'h10000, 64'h18000, 64'h14000, 0, 0, 8, 0, 0);
    checks++;
    if (root !== 20'h14000 || iters !== 8'd1 || status !== 2'b00) begin
      errors++;
      $display("FAIL exact_mid got root=%h it=%0d st=%0d exp 14000 1 0", root, iters, status);
    end
  endtask

  task automatic test_iter_limit;
    run_case(64'h10000, 64'h28000, 64'h18000, 0, 0, 4, 0, 0);
    checks++;
    if (root !== 20'h17800 || iters !== 8'd4 || status !== 2'b10) begin
      errors++;
      $display("FAIL iter_limit got root=%h it=%0d st=%0d exp 17800 4 2", root, iters, status);
    end
  endtask

  task automatic test_no_sign_change;
    run_case(64'h20000, 64'h28000, 64'h18000, 0, 0, 8, 0, 0);
    checks++;
    if (req_count != 2 || status !== 2'b11 || root !== 20'h20000 || iters !== 8'd0) begin
      errors++;
      $display("FAIL no_sign_change got reqs=%0d st=%0d root=%h it=%0d exp 2 3 20000 0",
               req_count, status, root, iters);
    end
  endtask

  task automatic test_endpoint_roots;
    run_case(64'h18000, 64'h28000, 64'h18000, 0, 0, 8, 0, 0);
    checks++;
    if (req_count != 2 || status !== 2'b00 || root !== 20'h18000) begin
      errors++;
      $display("FAIL fa_zero got reqs=%0d st=%0d root=%h exp 2 0 18000", req_count, status, root);
    end
    run_case(64'h10000, 64'h18000, 64'h18000, 0, 0, 8, 0, 0);
    run_case(64'h10000, 64'h28000, 64'h18000, 0, 0, 0, 0, 0);
  endtask

  task automatic test_tol_x;
    run_case(64'h10000, 64'h28000, 64'h18000, 0, 64'h4000, 20, 0, 0);
    checks++;
    if (status !== 2'b01) begin
      errors++;
      $display("FAIL tol_x_status got %0d exp 1", status);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit bad;
    stall_after = 2;
    @(negedge clk);
    k_val = 64'h18000;
    zero_wait = 0;
    obs_x.delete();
    req_count = 0;
    a_init = 20'h10000; b_init = 20'h28000; tol_f = '0; tol_x = '0; max_iter = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(req_count >= 3 && eval_req === 1'b1)) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (req_count < 3) begin
      errors++;
      $display("FAIL reset_mid_reach got %0d requests exp 3", req_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (eval_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got req=%b busy=%b done=%b exp 0 0 0", eval_req, busy, done);
    end
    stall_after = -1;
    spurious = 1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || eval_req !== 1'b0) bad = 1;
    end
    spurious = 0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_quiet got activity after reset exp idle");
    end
    run_case(64'h10000, 64'h28000, 64'h18000, 0, 0, 4, 0, 0);
  endtask

  task automatic test_zero_wait_busy_start;
    spurious = 1;
    run_case(64'h10000, 64'h28000, 64'h18000, 0, 0, 4, 1, 1);
    run_case(64'h10000, 64'h28000, 64'h18000, 0, 64'h4000, 20, 1, 1);
    spurious = 0;
  endtask

  task automatic test_random;
    longint a, b, k, tf, tx;
    int mi;
    for (int n = 0; n < 24; n++) begin
      a = longint'($urandom_range(0, 262144)) - 131072;
      b = a + longint'($urandom_range(1, 131072));
      if ($urandom_range(0, 3) != 0) k = a + longint'($urandom_range(0, int'(b - a)));
      else k = longint'($urandom_range(0, 393216)) - 196608;
      tf = ($urandom_range(0, 1) == 0) ? 0 : longint'($urandom_range(0, 1024));
      tx = longint'($urandom_range(0, 4096));
      mi = int'($urandom_range(0, 20));
      spurious = bit'($urandom_range(0, 1));
      run_case(a, b, k, tf, tx, mi, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    spurious = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset;
    test_exact_mid;
    test_iter_limit;
    test_no_sign_change;
    test_endpoint_roots;
    test_tol_x;
    test_reset_mid;
    test_zero_wait_busy_start;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
